// File: rtl/gate_tt_sweeper_if.sv
// gate_tt_sweeper_if: control/status bundle for the gate truth-table sweeper.
//   start            - one-cycle sweep request (master -> slave)
//   busy             - sweep in progress
//   done             - one-cycle pulse at sweep end
//   pass             - last sweep finished with no mismatches
//   fail_cnt         - mismatch count of the current/last sweep (N_IN+1 bits)
//   first_fail_vec   - input vector of the first mismatch
//   first_fail_valid - first_fail_vec is meaningful
// Modports: master = requester (testbench / self-check controller), slave = sweeper.
interface gate_tt_sweeper_if #(
    parameter int unsigned N_IN = 2
);
    logic            start;
    logic            busy;
    logic            done;
    logic            pass;
    logic [N_IN:0]   fail_cnt;
    logic [N_IN-1:0] first_fail_vec;
    logic            first_fail_valid;

    modport master (
        output start,
        input  busy, done, pass, fail_cnt, first_fail_vec, first_fail_valid
    );

    modport slave (
        input  start,
        output busy, done, pass, fail_cnt, first_fail_vec, first_fail_valid
    );
endinterface

// File: rtl/gate_tt_sweeper.sv
// gate_tt_sweeper: walks every input vector of an N_IN-input single-output gate in
// ascending order, waits SETTLE cycles, compares the gate output against TT and
// counts mismatches.
//   clk     - rising-edge clock
//   reset   - asynchronous active-high reset
//   ctrl    - gate_tt_sweeper_if.slave (start/busy/done/pass/fail_cnt/first_fail_*)
//   dut_in  - vector driven to the gate under test, bit 0 = input a
//   dut_out - gate output
// Optional build macro GATE_TT_SWEEPER_STOP_ON_FAIL_EN: the first mismatch ends the
// sweep immediately; otherwise every vector is swept and all mismatches counted.
module gate_tt_sweeper #(
    parameter int unsigned         N_IN   = 2,
    parameter int unsigned         SETTLE = 4,
    parameter logic [2**N_IN-1:0]  TT     = (2**N_IN)'(4'b1110)
) (
    input  logic              clk,
    input  logic              reset,
    gate_tt_sweeper_if.slave  ctrl,
    output logic [N_IN-1:0]   dut_in,
    input  logic              dut_out
);

    localparam int unsigned     NVec      = 2**N_IN;
    localparam logic [N_IN-1:0] LastVec   = '1;
    localparam logic [N_IN:0]   FailMax   = (N_IN+1)'(NVec);
    localparam logic [7:0]      SettleCyc = 8'(SETTLE);

    typedef enum logic [2:0] {StIdle, StDrive, StSettle, StCheck, StDone} state_e;

    state_e          state_q;
    logic [N_IN-1:0] vec_q;
    logic [7:0]      settle_q;

    logic            mismatch;
    logic [N_IN:0]   fail_inc;
    logic            last_step;

    // X/Z on the gate output counts as a mismatch in simulation.
    assign mismatch = (dut_out !== TT[vec_q]);
    assign fail_inc = (ctrl.fail_cnt == FailMax) ? ctrl.fail_cnt
                                                 : ctrl.fail_cnt + (N_IN+1)'(1);
`ifdef GATE_TT_SWEEPER_STOP_ON_FAIL_EN
    assign last_step = mismatch || (vec_q == LastVec);
`else
    assign last_step = (vec_q == LastVec);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q               <= StIdle;
            vec_q                 <= '0;
            settle_q              <= '0;
            dut_in                <= '0;
            ctrl.busy             <= 1'b0;
            ctrl.done             <= 1'b0;
            ctrl.pass             <= 1'b0;
            ctrl.fail_cnt         <= '0;
            ctrl.first_fail_vec   <= '0;
            ctrl.first_fail_valid <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    // Results of the previous sweep stay visible until a new start.
                    if (ctrl.start) begin
                        ctrl.fail_cnt         <= '0;
                        ctrl.pass             <= 1'b0;
                        ctrl.first_fail_valid <= 1'b0;
                        ctrl.first_fail_vec   <= '0;
                        vec_q                 <= '0;
                        ctrl.busy             <= 1'b1;
                        state_q               <= StDrive;
                    end
                end
                StDrive: begin
                    dut_in   <= vec_q;
                    settle_q <= SettleCyc;
                    state_q  <= (SETTLE == 0) ? StCheck : StSettle;
                end
                StSettle: begin
                    settle_q <= settle_q - 8'd1;
                    if (settle_q == 8'd1) begin
                        state_q <= StCheck;
                    end
                end
                StCheck: begin
                    if (mismatch) begin
                        ctrl.fail_cnt <= fail_inc;
                        if (!ctrl.first_fail_valid) begin
                            ctrl.first_fail_vec   <= vec_q;
                            ctrl.first_fail_valid <= 1'b1;
                        end
                    end
                    if (last_step) begin
                        ctrl.done <= 1'b1;
                        state_q   <= StDone;
                    end else begin
                        vec_q   <= vec_q + N_IN'(1);
                        state_q <= StDrive;
                    end
                end
                StDone: begin
                    // fail_cnt already includes any mismatch from the final CHECK.
                    ctrl.done <= 1'b0;
                    ctrl.pass <= (ctrl.fail_cnt == '0);
                    ctrl.busy <= 1'b0;
                    state_q   <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_tt_sweeper.sv
module tb_gate_tt_sweeper;

    typedef struct {
        int lat;
        int fcnt;
        int ffv;
        int ffvalid;
        int pass_v;
        int last_vec;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    gate_tt_sweeper_if #(.N_IN(2)) if_a ();
    gate_tt_sweeper_if #(.N_IN(2)) if_b ();

    logic [1:0] a_dut_in, b_dut_in;
    logic       a_dut_out, b_dut_out;
    int         mode_a = 0;
    int         mode_b = 0;

    // Gate models: mode 0 = correct gate, 1 = stuck-at-0, 2 = stuck-at-1.
    assign a_dut_out = (mode_a == 0) ? (|a_dut_in) : (mode_a == 2);
    assign b_dut_out = (mode_b == 0) ? (&b_dut_in) : (mode_b == 2);

    gate_tt_sweeper #(.N_IN(2), .SETTLE(4), .TT(4'b1110)) u_dut_a (
        .clk     (clk),
        .reset   (reset),
        .ctrl    (if_a),
        .dut_in  (a_dut_in),
        .dut_out (a_dut_out)
    );

    gate_tt_sweeper #(.N_IN(2), .SETTLE(0), .TT(4'b1000)) u_dut_b (
        .clk     (clk),
        .reset   (reset),
        .ctrl    (if_b),
        .dut_in  (b_dut_in),
        .dut_out (b_dut_out)
    );

    int sel = 0;
    logic       obs_busy, obs_done, obs_pass, obs_ffvalid;
    logic [2:0] obs_fcnt;
    logic [1:0] obs_ffv, obs_dut_in;
    assign obs_busy    = sel ? if_b.busy             : if_a.busy;
    assign obs_done    = sel ? if_b.done             : if_a.done;
    assign obs_pass    = sel ? if_b.pass             : if_a.pass;
    assign obs_ffvalid = sel ? if_b.first_fail_valid : if_a.first_fail_valid;
    assign obs_fcnt    = sel ? if_b.fail_cnt         : if_a.fail_cnt;
    assign obs_ffv     = sel ? if_b.first_fail_vec   : if_a.first_fail_vec;
    assign obs_dut_in  = sel ? b_dut_in              : a_dut_in;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb_q[$];
    int   vec_q[$];

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    task automatic set_start(input logic v);
        if (sel == 0) if_a.start = v;
        else          if_b.start = v;
    endtask

    // Reference model of one sweep on the selected instance.
    task automatic model(input int which, input int mode, output exp_t e, output int nvec);
        logic [3:0] tt;
        logic [1:0] vv;
        logic       g;
        int         settle;
        tt     = which ? 4'b1000 : 4'b1110;
        settle = which ? 0 : 4;
        e.fcnt = 0; e.ffv = 0; e.ffvalid = 0;
        nvec   = 0;
        for (int v = 0; v < 4; v++) begin
            vv   = v[1:0];
            nvec = v + 1;
            if (mode == 0) g = which ? (&vv) : (|vv);
            else           g = (mode == 2);
            if (g != tt[v]) begin
                e.fcnt++;
                if (e.ffvalid == 0) begin
                    e.ffv     = v;
                    e.ffvalid = 1;
                end
`ifdef GATE_TT_SWEEPER_STOP_ON_FAIL_EN
                break;
`endif
            end
        end
        e.lat      = nvec * (settle + 2) + 1;
        e.pass_v   = (e.fcnt == 0);
        e.last_vec = nvec - 1;
    endtask

    task automatic sweep(input string name, input int which, input int mode,
                         input bit mid_start);
        exp_t e, r;
        int   nvec, settle;
        bit   got;
        sel    = which;
        settle = which ? 0 : 4;
        if (which == 0) mode_a = mode;
        else            mode_b = mode;
        model(which, mode, e, nvec);
        @(negedge clk);
        set_start(1'b1);
        sb_q.push_back(e);
        for (int v = 0; v < nvec; v++) vec_q.push_back(v);
        @(posedge clk);
        #1;
        set_start(1'b0);
        check_eq({name, "_busy_after_accept"}, int'(obs_busy), 1);
        got = 0;
        for (int k = 1; k <= 200 && !got; k++) begin
            @(posedge clk);
            #1;
            set_start(mid_start && (k == 3));
            if (obs_done) begin
                got = 1;
                r   = sb_q.pop_front();
                check_eq({name, "_latency"}, k + 1, r.lat);
                check_eq({name, "_fail_cnt"}, int'(obs_fcnt), r.fcnt);
                check_eq({name, "_first_fail_valid"}, int'(obs_ffvalid), r.ffvalid);
                check_eq({name, "_first_fail_vec"}, int'(obs_ffv), r.ffv);
            end else if (((k - 1) % (settle + 2)) == 0 && vec_q.size() > 0) begin
                check_eq({name, "_dut_in_seq"}, int'(obs_dut_in), vec_q.pop_front());
            end
        end
        if (!got) begin
            check_eq({name, "_done_timeout"}, 0, 1);
            r = sb_q.pop_front();
        end
        check_eq({name, "_vectors_left"}, vec_q.size(), 0);
        vec_q.delete();
        @(posedge clk);
        #1;
        check_eq({name, "_done_one_cycle"}, int'(obs_done), 0);
        check_eq({name, "_busy_idle"}, int'(obs_busy), 0);
        check_eq({name, "_pass"}, int'(obs_pass), e.pass_v);
        check_eq({name, "_dut_in_hold"}, int'(obs_dut_in), e.last_vec);
        if (mid_start) begin
            repeat (3) begin
                @(posedge clk);
                #1;
                check_eq({name, "_no_restart"}, int'(obs_busy), 0);
            end
        end
    endtask

    initial begin
        if_a.start = 1'b0;
        if_b.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        sel = 0;
        check_eq("rst_dut_in", int'(obs_dut_in), 0);
        check_eq("rst_busy", int'(obs_busy), 0);
        check_eq("rst_done", int'(obs_done), 0);
        check_eq("rst_pass", int'(obs_pass), 0);
        check_eq("rst_fail_cnt", int'(obs_fcnt), 0);
        check_eq("rst_first_fail_vec", int'(obs_ffv), 0);
        check_eq("rst_first_fail_valid", int'(obs_ffvalid), 0);
        @(negedge clk);
        reset = 1'b0;

        sweep("or_ok", 0, 0, 1'b0);
        sweep("or_sa0", 0, 1, 1'b0);
        sweep("or_sa1", 0, 2, 1'b0);
        sweep("and_ok", 1, 0, 1'b0);
        sweep("and_ok_midstart", 1, 0, 1'b1);
        sweep("and_sa0", 1, 1, 1'b0);

        // Reset in the middle of vector 2's settle window.
        sel    = 0;
        mode_a = 1;
        @(negedge clk);
        if_a.start = 1'b1;
        @(posedge clk);
        #1;
        if_a.start = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        check_eq("pre_reset_fail_cnt", int'(obs_fcnt), 1);
        #2;
        reset = 1'b1;
        #1;
        check_eq("async_rst_dut_in", int'(obs_dut_in), 0);
        check_eq("async_rst_busy", int'(obs_busy), 0);
        check_eq("async_rst_fail_cnt", int'(obs_fcnt), 0);
        check_eq("async_rst_first_fail_valid", int'(obs_ffvalid), 0);
        check_eq("async_rst_first_fail_vec", int'(obs_ffv), 0);
        @(negedge clk);
        reset = 1'b0;
        sweep("after_reset", 0, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
